// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;
  localparam int REG_ZERO = 0;
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctl_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stage controls back to it
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, state, stall_count
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, state, stall_count
  );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading a nonzero register that the load in EX writes
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             hazard
);
  assign hazard = ex_mem_read && ex_rd != REG_W'(REG_ZERO) &&
                  ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage enables/flushes from memory waits, taken branches and load-use hazards
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic lu, freeze, lu_eff, hit;
  pipe_ctl_t ctl;
  load_use_detect #(.REG_W(REG_W)) u_lud (
    .id_rs(bus.id_rs),
    .id_rt(bus.id_rt),
    .id_uses_rs(bus.id_uses_rs),
    .id_uses_rt(bus.id_uses_rt),
    .ex_rd(bus.ex_rd),
    .ex_mem_read(bus.ex_mem_read),
    .hazard(lu)
  );
  assign freeze = bus.mem_req && !bus.mem_ready;
  assign lu_eff = lu && st != FLUSH;
  assign hit = freeze || bus.ex_branch_taken || lu_eff;
  // priority decode: freeze over branch over load-use; the ID slot is a bubble right after a flush
  always_comb begin
    ctl = reset                ? pipe_ctl_t'(7'b0000011) :
          freeze               ? pipe_ctl_t'(7'b0000000) :
          bus.ex_branch_taken  ? pipe_ctl_t'(7'b1111111) :
          lu_eff               ? pipe_ctl_t'(7'b0011101) :
                                 pipe_ctl_t'(7'b1111100);
    nxt = freeze ? MEM_WAIT : bus.ex_branch_taken ? FLUSH : lu_eff ? LOAD_STALL : RUN;
  end
  // state register and saturating lost-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= RUN;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (hit && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
  assign bus.pc_en       = ctl.pc_en;
  assign bus.if_id_en    = ctl.if_id_en;
  assign bus.id_ex_en    = ctl.id_ex_en;
  assign bus.ex_mem_en   = ctl.ex_mem_en;
  assign bus.mem_wb_en   = ctl.mem_wb_en;
  assign bus.if_id_flush = ctl.if_id_flush;
  assign bus.id_ex_flush = ctl.id_ex_flush;
  assign bus.state       = st;
  assign bus.stall_count = cnt;
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the per-stage register enables and flushes from three hazard sources:
- load-use hazards that forwarding cannot cover,
- taken branches resolved in EX,
- data-memory wait states.

It sits beside the forwarding unit: forwarding resolves ALU-to-ALU dependencies, and this block stalls or squashes the cases forwarding cannot. It also keeps a saturating lost-cycle counter.

## Interface
Parameters:
- REG_W, 3: register-address width; register 0 is hardwired zero.
- CNT_W, 16: width of the lost-cycle counter.

Ports (name, direction, width, meaning):
- clk, in, 1: sole clock; all state updates on rising edge.
- reset, in, 1: synchronous, active-high.
- id_rs, in, REG_W: Rs of the instruction in IF/ID.
- id_rt, in, REG_W: Rt of the instruction in IF/ID.
- id_uses_rs, in, 1: ID instruction reads Rs.
- id_uses_rt, in, 1: ID instruction reads Rt.
- ex_rd, in, REG_W: destination of the instruction in ID/EX.
- ex_mem_read, in, 1: instruction in ID/EX is a load.
- ex_branch_taken, in, 1: branch in EX resolved taken this cycle.
- mem_req, in, 1: MEM stage is accessing data memory.
- mem_ready, in, 1: data memory completes the access this cycle.
- pc_en, out, 1: PC load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en, out, 1 each: pipeline register enables.
- if_id_flush, id_ex_flush, out, 1 each: load a bubble (all-zero control) into that register at the next edge.
- state, out, 2: registered FSM state.
- stall_count, out, CNT_W: lost cycles since reset, saturating.

## Operation
- Control outputs are combinational (Mealy) from the current inputs and the registered state. `state` and `stall_count` are registered.

FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.

Per-cycle decision, highest priority first:
1. **Memory freeze** (`mem_req & !mem_ready`):
   - Outputs: all five enables 0, both flushes 0.
   - Next state: MEM_WAIT.
   - Branch and load-use inputs are ignored this cycle. They are re-evaluated when the freeze ends, because the pipeline contents are unchanged.
2. **Taken branch** (`ex_branch_taken`):
   - Outputs: all enables 1, `if_id_flush`=1, `id_ex_flush`=1.
   - Next state: FLUSH.
3. **Load-use hazard**:
   - Condition: `ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))`.
   - Outputs: `pc_en`=0, `if_id_en`=0, `id_ex_en`=1, `id_ex_flush`=1, `ex_mem_en`=1, `mem_wb_en`=1, `if_id_flush`=0.
   - Next state: LOAD_STALL.
4. **Otherwise**:
   - Outputs: all enables 1, no flush.
   - Next state: RUN.

Per-state rules:
- In FLUSH, load-use detection is suppressed for that one cycle because the ID contents are a bubble. Memory freeze and a taken branch are still honoured.
- LOAD_STALL and MEM_WAIT apply the same priority list. A second consecutive load-use is honoured if present.

Stall counter:
- `stall_count` increments by 1 on every cycle that falls into case 1, 2 or 3.
- It saturates at 2^CNT_W−1 and does not wrap.

Reset behaviour:
- While `reset`=1: all enables 0, `if_id_flush`=1, `id_ex_flush`=1.
- At the edge where `reset` is sampled high: `state`←RUN and `stall_count`←0.
- Reset mid-stall or mid-freeze abandons that condition with no residual effect.

## Timing
- Input to enable/flush: 0 cycles (same-cycle combinational).
- `state` and `stall_count` reflect a decision 1 cycle later.
- Load-use penalty: exactly 1 bubble. In the next cycle the load is in MEM and forwarding covers it.
- Taken-branch penalty: 2 squashed instructions in one flush cycle.
- Memory-wait cycles: one frozen cycle per cycle `mem_ready` is low. The pipeline resumes in the cycle `mem_ready` rises.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - `state_t` enum (RUN, LOAD_STALL, MEM_WAIT, FLUSH);
  - `REG_ZERO` constant;
  - a `pipe_ctl_t` packed struct bundling the 5 enables and 2 flushes.
- One combinational sub-module, `load_use_detect`: takes the ID/EX fields and returns a single hazard bit. It is reused for any later second-load-port extension.
- The FSM and counter stay in the top module.

## Test plan
- **Load-use:** load r3 in EX, ID reads r3 as Rs.
  - Same cycle: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
  - Next cycle: `state`=1, `stall_count`=1, all enables 1.
- **Zero-register exemption:** load r0 in EX, ID reads r0, or `id_uses_rt`=0 with Rt matching.
  - No stall; `stall_count` unchanged.
- **Taken branch coincident with load-use:**
  - `if_id_flush`=`id_ex_flush`=1, `pc_en`=1.
  - Next cycle: `state`=3, and a still-matching load-use in that cycle causes no stall.
- **Memory wait:** `mem_req`=1, `mem_ready` low 3 cycles with a taken branch pending.
  - All enables 0 for 3 cycles, `state`=2, `stall_count`=3.
  - The branch flush occurs in the 4th cycle, then `stall_count`=4.
- **Reset mid-MEM_WAIT:**
  - During reset: enables 0, both flushes 1.
  - Next cycle: `state`=0, `stall_count`=0.
- **Saturation:** with CNT_W=4, force 20 stall cycles.
  - `stall_count` holds at 15.
